// File: rtl/led_seq_monitor.sv
// Receive-side checker for the one-hot LED chase bus: decodes each sample, tracks the chase order,
// counts laps and sequence errors. Build option: define LEDMON_STALL_EN to accept repeated LEDs silently.
module led_seq_monitor #(
  parameter int LAP_W      = 8,
  parameter int ERR_W      = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk1h,
  input  logic             rst,
  input  logic [7:0]       led_in,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             locked,
  output logic [LAP_W-1:0] lap,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_pulse
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_expected, w_expected_nxt;
  logic [2:0]       r_idx;
  logic             r_idx_valid;
  logic [LAP_W-1:0] r_lap;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_err_pulse;

  logic [7:0]       w_v;
  logic             w_onehot;
  logic [2:0]       w_enc;
  logic             w_err;
  logic             w_lap_inc;

  assign w_v      = ACTIVE_LOW ? ~led_in : led_in;
  assign w_onehot = (w_v != 8'h00) && ((w_v & (w_v - 8'h01)) == 8'h00);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_v[i]) w_enc = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_err          = 1'b0;
    w_lap_inc      = 1'b0;
    unique case (r_state)
      SEARCH: begin
        if (w_onehot) begin
          w_state_nxt    = LOCK;
          w_expected_nxt = w_enc + 3'd1;
        end
      end
      LOCK: begin
        if (w_onehot && (w_enc == r_expected)) begin
          w_expected_nxt = w_enc + 3'd1;
          w_lap_inc      = (w_enc == 3'd0);
`ifdef LEDMON_STALL_EN
        end else if (w_onehot && (w_enc == r_expected - 3'd1)) begin
          // Repeated LED: hold position, nothing to count.
          w_expected_nxt = r_expected;
`endif
        end else begin
          w_err = 1'b1;
          if (w_onehot) begin
            w_expected_nxt = w_enc + 3'd1;
          end else begin
            w_state_nxt = SEARCH;
          end
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) begin
      r_state    <= SEARCH;
      r_expected <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
    end
  end

  always_ff @(posedge clk1h or negedge rst) begin
    if (!rst) begin
      r_idx       <= 3'd0;
      r_idx_valid <= 1'b0;
      r_lap       <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_idx       <= w_onehot ? w_enc : 3'd0;
      r_idx_valid <= w_onehot;
      r_err_pulse <= w_err;
      if (w_lap_inc) r_lap <= r_lap + LAP_W'(1);
      if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign idx       = r_idx;
  assign idx_valid = r_idx_valid;
  assign locked    = (r_state == LOCK);
  assign lap       = r_lap;
  assign err_cnt   = r_err_cnt;
  assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_led_seq_monitor.sv
// Bench for led_seq_monitor: a default instance and a narrow active-low instance see the same logical
// chase; a table of samples with expected outputs feeds a scoreboard checked after each edge.
module tb_led_seq_monitor;

  typedef struct {
    logic [7:0] led;
    int         idx;
    int         vld;
    int         lck;
    int         lap;
    int         err;
    int         pls;
  } vec_t;

`ifdef LEDMON_STALL_EN
  localparam int E = 0;
`else
  localparam int E = 1;
`endif

  logic       clk1h = 1'b0;
  logic       rst   = 1'b0;
  logic [7:0] led_in = 8'h00;

  logic [2:0] a_idx, b_idx;
  logic       a_vld, b_vld, a_lck, b_lck, a_pls, b_pls;
  logic [7:0] a_lap, a_err;
  logic [1:0] b_lap, b_err;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vec[$];
  vec_t sb[$];

  always #5 clk1h = ~clk1h;

  led_seq_monitor dut_a (
    .clk1h(clk1h), .rst(rst), .led_in(led_in),
    .idx(a_idx), .idx_valid(a_vld), .locked(a_lck),
    .lap(a_lap), .err_cnt(a_err), .err_pulse(a_pls)
  );

  led_seq_monitor #(.LAP_W(2), .ERR_W(2), .ACTIVE_LOW(1'b1)) dut_b (
    .clk1h(clk1h), .rst(rst), .led_in(~led_in),
    .idx(b_idx), .idx_valid(b_vld), .locked(b_lck),
    .lap(b_lap), .err_cnt(b_err), .err_pulse(b_pls)
  );

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Narrow instance: lap wraps mod 4, error count sticks at 3.
  task automatic cmp_all(input string tag, input vec_t e);
    check({tag, " a.idx"}, int'(a_idx), e.idx);
    check({tag, " a.idx_valid"}, int'(a_vld), e.vld);
    check({tag, " a.locked"}, int'(a_lck), e.lck);
    check({tag, " a.lap"}, int'(a_lap), e.lap % 256);
    check({tag, " a.err_cnt"}, int'(a_err), e.err);
    check({tag, " a.err_pulse"}, int'(a_pls), e.pls);
    check({tag, " b.idx"}, int'(b_idx), e.idx);
    check({tag, " b.idx_valid"}, int'(b_vld), e.vld);
    check({tag, " b.locked"}, int'(b_lck), e.lck);
    check({tag, " b.lap"}, int'(b_lap), e.lap % 4);
    check({tag, " b.err_cnt"}, int'(b_err), (e.err > 3) ? 3 : e.err);
    check({tag, " b.err_pulse"}, int'(b_pls), e.pls);
  endtask

  task automatic add(input logic [7:0] led, input int i, input int v, input int l,
                     input int lp, input int er, input int p);
    vec_t t;
    t.led = led; t.idx = i; t.vld = v; t.lck = l; t.lap = lp; t.err = er; t.pls = p;
    vec.push_back(t);
  endtask

  // Called during the low phase: drive, let one edge sample, compare, return in the next low phase.
  task automatic step(input string tag, input vec_t e);
    vec_t got;
    led_in = e.led;
    sb.push_back(e);
    @(posedge clk1h);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard underflow"}, 0, 1);
    end else begin
      got = sb.pop_front();
      cmp_all(tag, got);
    end
    @(negedge clk1h);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t z;
    z.led = 8'h00; z.idx = 0; z.vld = 0; z.lck = 0; z.lap = 0; z.err = 0; z.pls = 0;

    // Clean chase, 17 edges: lap counts the two 7->0 wraps while locked.
    for (int k = 0; k < 17; k++) add(8'h01 << (k % 8), k % 8, 1, 1, k / 8, 0, 0);
    // Skip over index 2, then resume.
    add(8'h02, 1, 1, 1, 2, 0, 0);
    add(8'h08, 3, 1, 1, 2, 1, 1);
    add(8'h10, 4, 1, 1, 2, 1, 0);
    // Blank bus drops lock; multi-hot in SEARCH is silent; one-hot relocks.
    add(8'h00, 0, 0, 0, 2, 2, 1);
    add(8'h24, 0, 0, 0, 2, 2, 0);
    add(8'h10, 4, 1, 1, 2, 2, 0);
    // Repeated LED.
    add(8'h20, 5, 1, 1, 2, 2, 0);
    add(8'h20, 5, 1, 1, 2, 2 + E, E);
    add(8'h40, 6, 1, 1, 2, 2 + E, 0);
    add(8'h80, 7, 1, 1, 2, 2 + E, 0);
    add(8'h01, 0, 1, 1, 3, 2 + E, 0);
    // Five back-to-back resync errors; index 0 on a resync is not a lap.
    for (int j = 0; j < 5; j++)
      add((j % 2 == 0) ? 8'h04 : 8'h01, (j % 2 == 0) ? 2 : 0, 1, 1, 3, 3 + E + j, 1);
    // Two more laps: narrow lap counter wraps 3 -> 0 -> 1.
    for (int k = 3; k < 17; k++) add(8'h01 << (k % 8), k % 8, 1, 1, 3 + k / 8, 7 + E, 0);

    // Reset held with random bus activity.
    for (int c = 0; c < 3; c++) begin
      led_in = 8'($urandom);
      @(posedge clk1h);
      #1;
      cmp_all($sformatf("reset_hold[%0d]", c), z);
    end
    @(negedge clk1h);
    #2 rst = 1'b1;

    for (int i = 0; i < vec.size(); i++) step($sformatf("vec[%0d]", i), vec[i]);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    #1 rst = 1'b0;
    #1 cmp_all("async_reset", z);
    led_in = 8'h02;
    @(posedge clk1h);
    #1 cmp_all("reset_edge", z);
    @(negedge clk1h);
    #2 rst = 1'b1;
    begin
      vec_t t;
      t = z; t.led = 8'h08; t.idx = 3; t.vld = 1; t.lck = 1;
      step("post_reset_first", t);
      t.led = 8'h10; t.idx = 4;
      step("post_reset_next", t);
      t.led = 8'h00; t.idx = 0; t.vld = 0; t.lck = 0; t.err = 1; t.pls = 1;
      step("post_reset_blank", t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
